// File: rtl/isqrt_pipe_with_valid_if.sv
// rtl/isqrt_pipe_with_valid_if.sv - argument/result handshake bundle for the pipelined isqrt
//
// Signals:
//   arg_vld  master->slave  x is a new argument this cycle
//   x        master->slave  unsigned radicand, width bits
//   res_vld  slave->master  y is a new result this cycle
//   y        slave->master  floor(sqrt(x)), width/2 bits
// Modports:
//   master  argument producer / result consumer (testbench, formula datapath)
//   slave   the square-root pipeline
interface isqrt_pipe_with_valid_if #(
  parameter int width = 32
);
  logic                 arg_vld;
  logic [width-1:0]     x;
  logic                 res_vld;
  logic [width/2-1:0]   y;

  modport master (
    output arg_vld,
    output x,
    input  res_vld,
    input  y
  );

  modport slave (
    input  arg_vld,
    input  x,
    output res_vld,
    output y
  );
endinterface

// File: rtl/isqrt_pipe_with_valid.sv
// rtl/isqrt_pipe_with_valid.sv - fully pipelined floor(sqrt(x)) with a travelling valid bit
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears every valid and data register
//   bus   isqrt_pipe_with_valid_if.slave: arg_vld/x in, res_vld/y out
// Parameters:
//   width     radicand width (even, >= 4); result is width/2 bits
//   n_stages  width/2 pipeline stages, one root bit resolved per stage
// Build option:
//   ISQRT_PIPE_OUT_REG_EN  adds a registered output stage (latency n_stages+1)
module isqrt_pipe_with_valid #(
  parameter int width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  isqrt_pipe_with_valid_if.slave  bus
);

  localparam int n_stages = width / 2;
  localparam int hw       = width / 2;  // root width
  localparam int rw       = hw + 2;     // remainder width

  // Registered outputs of every stage, exposed as flat arrays so the next
  // stage can pick them up. The last stage only needs valid and root, so the
  // remainder/radicand arrays stop one stage short.
  logic              w_vld  [n_stages];
  logic [hw-1:0]     w_root [n_stages];
  logic [rw-1:0]     w_rem  [n_stages-1];
  logic [width-1:0]  w_rad  [n_stages-1];

  for (genvar i = 0; i < n_stages; i++) begin : g_stage
    logic              w_in_vld;
    logic [width-1:0]  w_in_rad;
    logic [hw-1:0]     w_in_root;
    logic [rw-1:0]     w_in_rem;

    logic [1:0]        w_d;
    logic [rw-1:0]     w_sh;
    logic [rw-1:0]     w_trial;
    logic [rw:0]       w_diff;
    logic              w_borrow;
    logic [hw-1:0]     w_nxt_root;

    logic              r_vld;
    logic [hw-1:0]     r_root;

    if (i == 0) begin : g_first
      // The first stage starts from an empty root and remainder.
      assign w_in_vld  = bus.arg_vld;
      assign w_in_rad  = bus.x;
      assign w_in_root = '0;
      assign w_in_rem  = '0;
    end else begin : g_next
      assign w_in_vld  = w_vld[i-1];
      assign w_in_rad  = w_rad[i-1];
      assign w_in_root = w_root[i-1];
      assign w_in_rem  = w_rem[i-1];
    end

    // Bring down the next two radicand bits and try to subtract 4r+1.
    // The remainder never exceeds 2r, so dropping its top two bits in the
    // shift is lossless; the extra diff bit is the borrow.
    assign w_d        = w_in_rad[width-1 -: 2];
    assign w_sh       = {w_in_rem[rw-3:0], w_d};
    assign w_trial    = {w_in_root, 2'b01};
    assign w_diff     = {1'b0, w_sh} - {1'b0, w_trial};
    assign w_borrow   = w_diff[rw];
    // At stage i the incoming root has only i significant bits, so the
    // top bit is always zero and can be shifted out.
    assign w_nxt_root = {w_in_root[hw-2:0], ~w_borrow};

    // Valid bit runs free; the data registers only load behind a valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_root <= '0;
      end else begin
        r_vld <= w_in_vld;
        if (w_in_vld) begin
          r_root <= w_nxt_root;
        end
      end
    end

    assign w_vld[i]  = r_vld;
    assign w_root[i] = r_root;

    if (i < n_stages - 1) begin : g_carry
      logic [rw-1:0]     w_nxt_rem;
      logic [width-1:0]  r_rem;
      logic [width-1:0]  r_rad_unused_guard;
      logic [rw-1:0]     r_rem_q;

      assign w_nxt_rem = w_borrow ? w_sh : w_diff[rw-1:0];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rem_q <= '0;
          r_rem   <= '0;
        end else if (w_in_vld) begin
          r_rem_q <= w_nxt_rem;
          // Consumed bits are shifted out so the next stage always looks
          // at the top two bits.
          r_rem   <= {w_in_rad[width-3:0], 2'b00};
        end
      end

      assign r_rad_unused_guard = r_rem;
      assign w_rem[i] = r_rem_q;
      assign w_rad[i] = r_rad_unused_guard;
    end
  end

`ifdef ISQRT_PIPE_OUT_REG_EN
  logic           r_out_vld;
  logic [hw-1:0]  r_out_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_y   <= '0;
    end else begin
      r_out_vld <= w_vld[n_stages-1];
      if (w_vld[n_stages-1]) begin
        r_out_y <= w_root[n_stages-1];
      end
    end
  end

  assign bus.res_vld = r_out_vld;
  assign bus.y       = r_out_y;
`else
  assign bus.res_vld = w_vld[n_stages-1];
  assign bus.y       = w_root[n_stages-1];
`endif

endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// tb/tb_isqrt_pipe_with_valid.sv - scoreboard bench for isqrt_pipe_with_valid (width 32 and 8)
module tb_isqrt_pipe_with_valid;

  localparam int W32 = 32;
  localparam int W8  = 8;
`ifdef ISQRT_PIPE_OUT_REG_EN
  localparam int LAT32 = W32 / 2 + 1;
  localparam int LAT8  = W8 / 2 + 1;
`else
  localparam int LAT32 = W32 / 2;
  localparam int LAT8  = W8 / 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt_pipe_with_valid_if #(.width(W32)) bus32 ();
  isqrt_pipe_with_valid_if #(.width(W8))  bus8 ();

  isqrt_pipe_with_valid #(.width(W32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  isqrt_pipe_with_valid #(.width(W8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] y;
    int          issue;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [15:0] y;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  vec_t vecs[14];

  logic [15:0] prev_y32 = '0;
  logic [15:0] prev_y8  = '0;

  // Reference: largest y with y*y <= x, found by binary search.
  function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
    longint lo = 0;
    longint hi = 65535;
    longint mid;
    longint xv = longint'({32'd0, x});
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= xv) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_y32 = bus32.y;
    end else begin
      if (bus32.res_vld) begin
        if (q32.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious32: res_vld with y=%0h but nothing outstanding (cycle %0d)", bus32.y, cyc);
        end else begin
          e = q32.pop_front();
          check("y32", {16'd0, bus32.y}, {16'd0, e.y});
          check("lat32", cyc - e.issue, LAT32);
        end
      end else begin
        check("hold32", {16'd0, bus32.y}, {16'd0, prev_y32});
      end
      prev_y32 = bus32.y;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_y8 = {12'd0, bus8.y};
    end else begin
      if (bus8.res_vld) begin
        if (q8.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious8: res_vld with y=%0h but nothing outstanding (cycle %0d)", bus8.y, cyc);
        end else begin
          e = q8.pop_front();
          check("y8", {28'd0, bus8.y}, {16'd0, e.y});
          check("lat8", cyc - e.issue, LAT8);
        end
      end else begin
        check("hold8", {28'd0, bus8.y}, {16'd0, prev_y8});
      end
      prev_y8 = {12'd0, bus8.y};
    end
  end

  task automatic drive32(input logic v, input logic [31:0] x, input logic [15:0] exp_y);
    @(posedge clk);
    #1;
    bus32.arg_vld = v;
    bus32.x       = v ? x : $urandom();
    if (v) q32.push_back('{y: exp_y, issue: cyc});
  endtask

  task automatic drive8(input logic v, input logic [7:0] x, input logic [15:0] exp_y);
    @(posedge clk);
    #1;
    bus8.arg_vld = v;
    bus8.x       = v ? x : 8'($urandom());
    if (v) q8.push_back('{y: exp_y, issue: cyc});
  endtask

  task automatic idle32(input int n);
    repeat (n) drive32(1'b0, 32'd0, 16'd0);
  endtask

  initial begin
    logic [31:0] rx;
    int issued;
    int t;

    vecs[0]  = '{32'd0,          16'd0};
    vecs[1]  = '{32'd1,          16'd1};
    vecs[2]  = '{32'd15,         16'd3};
    vecs[3]  = '{32'd16,         16'd4};
    vecs[4]  = '{32'd17,         16'd4};
    vecs[5]  = '{32'hFFFF_FFFF,  16'hFFFF};
    vecs[6]  = '{32'hFFFE_0001,  16'hFFFF};
    vecs[7]  = '{32'hFFFE_0000,  16'hFFFE};
    vecs[8]  = '{32'd144,        16'd12};
    vecs[9]  = '{32'd2,          16'd1};
    vecs[10] = '{32'd3,          16'd1};
    vecs[11] = '{32'd4,          16'd2};
    vecs[12] = '{32'd1000000,    16'd1000};
    vecs[13] = '{32'h4000_0000,  16'h8000};

    bus32.arg_vld = 1'b0;
    bus32.x       = '0;
    bus8.arg_vld  = 1'b0;
    bus8.x        = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_vld32", {31'd0, bus32.res_vld}, 32'd0);
    check("rst_y32",   {16'd0, bus32.y},       32'd0);
    check("rst_vld8",  {31'd0, bus8.res_vld},  32'd0);
    check("rst_y8",    {28'd0, bus8.y},        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single arguments with idle gaps.
    for (int i = 0; i < 14; i++) begin
      drive32(1'b1, vecs[i].x, vecs[i].y);
      idle32(LAT32 + 2);
    end

    // Back-to-back burst 0..99.
    for (int i = 0; i < 100; i++) begin
      drive32(1'b1, 32'(i), ref_isqrt(32'(i)));
    end
    idle32(LAT32 + 2);

    // Random arguments with ~50% bubbles.
    issued = 0;
    while (issued < 1000) begin
      if ($urandom_range(1, 0) == 1) begin
        rx = $urandom();
        drive32(1'b1, rx, ref_isqrt(rx));
        issued++;
      end else begin
        drive32(1'b0, 32'd0, 16'd0);
      end
    end
    idle32(LAT32 + 2);

    // Reset mid-stream: y currently holds the last random result.
    for (int i = 0; i < 8; i++) begin
      rx = $urandom() | 32'h0100_0000;
      drive32(1'b1, rx, ref_isqrt(rx));
    end
    idle32(5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_vld32", {31'd0, bus32.res_vld}, 32'd0);
    check("async_rst_y32",   {16'd0, bus32.y},       32'd0);
    q32.delete();
    q8.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle32(LAT32 + 6);
    drive32(1'b1, 32'd144, 16'd12);
    idle32(LAT32 + 2);

    // Narrow instance: exhaustive 0..255 back-to-back.
    for (int i = 0; i < 256; i++) begin
      drive8(1'b1, 8'(i), ref_isqrt(32'(i)));
    end
    drive8(1'b0, 8'd0, 16'd0);

    t = 0;
    while ((q32.size() != 0 || q8.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", 32'(q32.size() + q8.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
